data_mem_ws: RTL and testbench
==============================

// Module: data_mem_ws
// PURPOSE
//  Parametrised word-addressed data memory with byte-enable writes, a req/ready/ack handshake and a
//  programmable number of wait states. Successor to the single-cycle combinational-read memory:
//  read data is registered, accesses take WS+1 cycles, and the block models slower data memory for
//  multi-cycle and pipelined datapaths. Sits between the datapath load/store stage and storage.
// PARAMETERS
//  N   32  data word width in bits; must be a multiple of 8
//  M   10  word address bits; depth = 2**M words
//  WS  2   wait states per access, 0..15
// PORTS
//  clock  in   1      single clock; all state updates on posedge
//  reset  in   1      asynchronous, active-high; returns FSM and outputs to reset values
//  req    in   1      access request; held by requester until accepted
//  we     in   1      1 = write, 0 = read; sampled on the acceptance edge
//  addr   in   M      word address; sampled on the acceptance edge
//  be     in   N/8    byte enables for writes; bit j covers in[8j+7:8j]
//  in     in   N      write data; sampled on the acceptance edge
//  ready  out  1      1 when a request can be accepted
//  ack    out  1      one-cycle pulse: access complete, out valid
//  out    out  N      registered read data (for writes: merged word after the write)
//  rd_cnt out  16     completed reads, saturating (MEM_STATS_EN only)
//  wr_cnt out  16     completed writes, saturating (MEM_STATS_EN only)
// BEHAVIOUR
//  - Reset values: state IDLE, ready=1, ack=0, out=0, wait counter=0, rd_cnt=wr_cnt=0.
//  - Memory contents are not cleared by reset; at time 0 word i holds value i (zero-extended to N).
//  - FSM IDLE/WAIT/RESP. ready = (state==IDLE). Acceptance = req & ready at a posedge; addr/we/be/in latched.
//  - IDLE: on acceptance -> WAIT with cnt=WS-1 if WS>0; if WS==0 perform access, -> RESP.
//  - WAIT: cnt decrements each cycle; on the edge where cnt==0 perform access, -> RESP.
//  - Access: read loads out<=mem[a]; write updates enabled bytes of mem[a] and loads out with merged word.
//  - RESP: ack=1 for exactly one cycle, ready=0; unconditionally -> IDLE. Latency: ack in the cycle after
//    edge (accept+WS); throughput one access per WS+2 cycles.
//  - req while ready=0 is ignored (no queuing); out holds its value between acks.
//  - we=1 with be=0: memory unchanged, out=current word, ack still issued, counted as a write.
//  - addr uses all M bits; no out-of-range case. Read of a just-written word returns the new value.
//  - Reset asserted in WAIT: access aborted, pending write never committed, no ack.
//  - Reset asserted in RESP: ack drops immediately (async), the committed write remains.
// CONFIGURATION
//  - MEM_STATS_EN defined: rd_cnt/wr_cnt increment on the edge entering RESP for reads/writes,
//    saturate at 16'hFFFF, cleared only by reset.
//  - MEM_STATS_EN undefined: no counter flops; rd_cnt and wr_cnt tied to 16'h0000.
// STRUCTURE
//  - Shared package mem_pkg: FSM state encoding (IDLE/WAIT/RESP localparams), wait-counter width (4),
//    stats counter width (16), byte-merge function merge_be(old,new,be).
//  - One sub-module mem_array: 2**M x N storage, time-0 init, async read, sync byte-enabled write.
//  - Top holds FSM, request latch, wait counter, out register and optional stats counters.
// TESTING
//  - Reset, WS=2: req read addr=5 -> accept edge, ack one cycle 3 edges later, out=32'h5, ready back to 1.
//  - Write addr=7 in=32'hAABBCCDD be=4'b0101 -> out=32'h00BB00DD; read addr=7 returns 32'h00BB00DD.
//  - WS=0: back-to-back reads addr=1,2 with req held high -> acks in alternate cycles, out=1 then 2.
//  - req asserted during WAIT/RESP -> ignored until ready=1; addr=10'h3FF read returns 32'h3FF.
//  - Reset mid-WAIT on write addr=9 in=32'hFFFF_FFFF -> no ack; later read addr=9 returns 32'h9.
//  - MEM_STATS_EN: 3 reads, 2 writes -> rd_cnt=3, wr_cnt=2; without macro both read 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the wait-state data memory: FSM encoding, counter widths
// and the byte-enable merge helper.
package mem_pkg;

    localparam int CNT_W   = 4;
    localparam int STAT_W  = 16;
    localparam int MERGE_W = 1024;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        WAIT = S_WAIT,
        RESP = S_RESP
    } state_t;

    // Operates at a fixed maximum width; callers zero-extend and truncate to their word size.
    function automatic logic [MERGE_W-1:0] merge_be(
        input logic [MERGE_W-1:0]   old_w,
        input logic [MERGE_W-1:0]   new_w,
        input logic [MERGE_W/8-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_w;
        for (int j = 0; j < MERGE_W / 8; j++) begin
            if (be[j]) res[8*j +: 8] = new_w[8*j +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Storage for data_mem_ws: 2**M words of N bits, asynchronous read, synchronous
// byte-enabled write. Word i powers up holding the value i.
module mem_array #(
    parameter int N = 32,
    parameter int M = 10
) (
    input  logic             clock,
    input  logic             we,
    input  logic [M-1:0]     waddr,
    input  logic [N/8-1:0]   be,
    input  logic [N-1:0]     wdata,
    input  logic [M-1:0]     raddr,
    output logic [N-1:0]     rdata
);

    localparam int DEPTH = 2 ** M;

    logic [N-1:0] words [DEPTH];

    // One register per word so each can carry its own power-up value.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [N-1:0] word = N'(i);

        always_ff @(posedge clock) begin
            if (we && waddr == M'(i)) begin
                for (int j = 0; j < N / 8; j++) begin
                    if (be[j]) word[8*j +: 8] <= wdata[8*j +: 8];
                end
            end
        end

        assign words[i] = word;
    end

    assign rdata = words[raddr];

endmodule

// File: rtl/data_mem_ws.sv
// Word-addressed data memory with req/ready/ack handshake and WS wait states.
// Define MEM_STATS_EN to build the saturating read/write completion counters.
module data_mem_ws
    import mem_pkg::*;
#(
    parameter int N  = 32,
    parameter int M  = 10,
    parameter int WS = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [M-1:0]      addr,
    input  logic [N/8-1:0]    be,
    input  logic [N-1:0]      in,
    output logic              ready,
    output logic              ack,
    output logic [N-1:0]      out,
    output logic [STAT_W-1:0] rd_cnt,
    output logic [STAT_W-1:0] wr_cnt
);

    localparam int BW = N / 8;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic [M-1:0]     addr_p0;
    logic             we_p0;
    logic [BW-1:0]    be_p0;
    logic [N-1:0]     in_p0;

    logic             accept;
    logic             access;
    logic [M-1:0]     acc_addr;
    logic             acc_we;
    logic [BW-1:0]    acc_be;
    logic [N-1:0]     acc_in;
    logic [N-1:0]     rdata;
    logic [N-1:0]     merged;
    logic [N-1:0]     acc_word;

    assign accept = req & ready;

    // With no wait states the access happens on the acceptance edge, so the live inputs are used.
    always_comb begin
        acc_addr = addr_p0;
        acc_we   = we_p0;
        acc_be   = be_p0;
        acc_in   = in_p0;
        if (state == IDLE) begin
            acc_addr = addr;
            acc_we   = we;
            acc_be   = be;
            acc_in   = in;
        end
    end

    assign access = ((state == IDLE) && accept && (WS == 0)) ||
                    ((state == WAIT) && (cnt == '0));

    assign merged   = N'(merge_be(MERGE_W'(rdata), MERGE_W'(acc_in), (MERGE_W/8)'(acc_be)));
    assign acc_word = acc_we ? merged : rdata;

    mem_array #(
        .N (N),
        .M (M)
    ) u_array (
        .clock (clock),
        .we    (access & acc_we),
        .waddr (acc_addr),
        .be    (acc_be),
        .wdata (acc_in),
        .raddr (acc_addr),
        .rdata (rdata)
    );

    // Request latch: data only, captured on acceptance
    always_ff @(posedge clock) begin
        if (accept) begin
            addr_p0 <= addr;
            we_p0   <= we;
            be_p0   <= be;
            in_p0   <= in;
        end
    end

    // Handshake FSM and response register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            ready <= 1'b1;
            ack   <= 1'b0;
            out   <= '0;
        end else begin
            ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        ready <= 1'b0;
                        if (WS == 0) begin
                            out   <= acc_word;
                            ack   <= 1'b1;
                            state <= RESP;
                        end else begin
                            cnt   <= CNT_W'(WS - 1);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        out   <= acc_word;
                        ack   <= 1'b1;
                        state <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_STATS_EN
    logic [STAT_W-1:0] rd_q;
    logic [STAT_W-1:0] wr_q;

    // Counters advance on the edge that enters RESP and stick at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_q <= '0;
            wr_q <= '0;
        end else if (access) begin
            if (acc_we) begin
                if (wr_q != '1) wr_q <= wr_q + STAT_W'(1);
            end else begin
                if (rd_q != '1) rd_q <= rd_q + STAT_W'(1);
            end
        end
    end

    assign rd_cnt = rd_q;
    assign wr_cnt = wr_q;
`else
    assign rd_cnt = '0;
    assign wr_cnt = '0;
`endif

endmodule

// File: tb/tb_data_mem_ws.sv
// Directed bench for data_mem_ws: a WS=2 instance driven from a vector table plus
// hand-written reset and back-pressure sequences, and a WS=0 instance for back-to-back reads.
module tb_data_mem_ws;

    logic        clock;
    logic        reset;

    logic        req, we;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] din;
    logic        ready, ack;
    logic [31:0] dout;
    logic [15:0] rd_cnt, wr_cnt;

    logic        req0, we0;
    logic [9:0]  addr0;
    logic [3:0]  be0;
    logic [31:0] din0;
    logic        ready0, ack0;
    logic [31:0] dout0;
    logic [15:0] rd_cnt0, wr_cnt0;

    int passed = 0;
    int total  = 0;

`ifdef MEM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    data_mem_ws #(.N(32), .M(10), .WS(2)) dut (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .be     (be),
        .in     (din),
        .ready  (ready),
        .ack    (ack),
        .out    (dout),
        .rd_cnt (rd_cnt),
        .wr_cnt (wr_cnt)
    );

    data_mem_ws #(.N(32), .M(10), .WS(0)) dut0 (
        .clock  (clock),
        .reset  (reset),
        .req    (req0),
        .we     (we0),
        .addr   (addr0),
        .be     (be0),
        .in     (din0),
        .ready  (ready0),
        .ack    (ack0),
        .out    (dout0),
        .rd_cnt (rd_cnt0),
        .wr_cnt (wr_cnt0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        w;
        logic [9:0]  a;
        logic [3:0]  b;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, required %h", nm, act, exp);
    endtask

    // Wait (bounded) for ack on the WS=2 instance; returns negedges counted since acceptance.
    task automatic wait_ack(inout int lat);
        while (ack !== 1'b1 && lat < 20) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic run2(input logic w, input logic [9:0] a, input logic [3:0] b,
                        input logic [31:0] d, output logic [31:0] got, output int lat);
        @(negedge clock);
        req  = 1'b1;
        we   = w;
        addr = a;
        be   = b;
        din  = d;
        @(negedge clock);
        req = 1'b0;
        lat = 1;
        wait_ack(lat);
        got = dout;
        @(negedge clock);
        chk("ack_one_cycle", 32'(ack), 32'h0);
        chk("ready_after_ack", 32'(ready), 32'h1);
    endtask

    logic [31:0] got;
    int          lat;

    initial begin
        vecs[0] = '{1'b0, 10'd5,   4'b0000, 32'h0,        32'h0000_0005};
        vecs[1] = '{1'b1, 10'd7,   4'b0101, 32'hAABBCCDD, 32'h00BB_00DD};
        vecs[2] = '{1'b0, 10'd7,   4'b0000, 32'h0,        32'h00BB_00DD};
        vecs[3] = '{1'b0, 10'h3FF, 4'b0000, 32'h0,        32'h0000_03FF};
        vecs[4] = '{1'b1, 10'd20,  4'b0000, 32'h12345678, 32'h0000_0014};
        vecs[5] = '{1'b0, 10'd20,  4'b0000, 32'h0,        32'h0000_0014};
        vecs[6] = '{1'b1, 10'd20,  4'b1111, 32'hDEADBEEF, 32'hDEAD_BEEF};
        vecs[7] = '{1'b0, 10'd20,  4'b0000, 32'h0,        32'hDEAD_BEEF};
        vecs[8] = '{1'b1, 10'd20,  4'b1000, 32'h11223344, 32'h11AD_BEEF};

        reset = 1'b1;
        req = 1'b0;  we = 1'b0;  addr = '0;  be = '0;  din = '0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; be0 = '0; din0 = '0;
        repeat (2) @(negedge clock);
        chk("reset_ready", 32'(ready), 32'h1);
        chk("reset_ack", 32'(ack), 32'h0);
        chk("reset_out", dout, 32'h0);
        chk("reset_rd_cnt", 32'(rd_cnt), 32'h0);
        chk("reset_wr_cnt", 32'(wr_cnt), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run2(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].d, got, lat);
            chk($sformatf("vec%0d_out", i), got, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
        end
        chk("stats_rd", 32'(rd_cnt), STATS ? 32'd5 : 32'd0);
        chk("stats_wr", 32'(wr_cnt), STATS ? 32'd4 : 32'd0);

        // req held through WAIT/RESP with a changed address: only taken once ready returns
        @(negedge clock);
        req = 1'b1; we = 1'b0; addr = 10'd1; be = '0;
        @(negedge clock);
        addr = 10'd2;
        chk("busy_ready_low", 32'(ready), 32'h0);
        lat = 1;
        wait_ack(lat);
        chk("busy_first_out", dout, 32'h1);
        chk("busy_first_latency", 32'(lat), 32'd3);
        @(negedge clock);
        chk("busy_ready_back", 32'(ready), 32'h1);
        chk("busy_ack_low", 32'(ack), 32'h0);
        @(negedge clock);
        req = 1'b0;
        lat = 1;
        wait_ack(lat);
        chk("busy_second_out", dout, 32'h2);
        chk("busy_second_latency", 32'(lat), 32'd3);
        @(negedge clock);

        // Reset during RESP: ack drops at once, the write stays committed
        @(negedge clock);
        req = 1'b1; we = 1'b1; addr = 10'd11; be = 4'b1111; din = 32'hCAFEF00D;
        @(negedge clock);
        req = 1'b0;
        lat = 1;
        wait_ack(lat);
        chk("resp_ack_seen", 32'(ack), 32'h1);
        reset = 1'b1;
        #1;
        chk("resp_reset_ack", 32'(ack), 32'h0);
        chk("resp_reset_ready", 32'(ready), 32'h1);
        chk("resp_reset_out", dout, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        run2(1'b0, 10'd11, 4'b0000, 32'h0, got, lat);
        chk("resp_write_kept", got, 32'hCAFEF00D);

        // Reset during WAIT: the pending write is dropped and no ack appears
        @(negedge clock);
        req = 1'b1; we = 1'b1; addr = 10'd9; be = 4'b1111; din = 32'hFFFF_FFFF;
        @(negedge clock);
        req = 1'b0;
        chk("wait_ready_low", 32'(ready), 32'h0);
        reset = 1'b1;
        @(negedge clock);
        chk("wait_reset_ack", 32'(ack), 32'h0);
        reset = 1'b0;
        @(negedge clock);
        chk("wait_reset_ack_after", 32'(ack), 32'h0);
        chk("wait_reset_ready", 32'(ready), 32'h1);
        run2(1'b0, 10'd9, 4'b0000, 32'h0, got, lat);
        chk("wait_write_dropped", got, 32'h9);
        chk("stats_rd_after_reset", 32'(rd_cnt), STATS ? 32'd1 : 32'd0);
        chk("stats_wr_after_reset", 32'(wr_cnt), 32'd0);

        // WS=0: back-to-back reads with req held high
        @(negedge clock);
        req0 = 1'b1; we0 = 1'b0; addr0 = 10'd1;
        @(negedge clock);
        chk("ws0_ack1", 32'(ack0), 32'h1);
        chk("ws0_out1", dout0, 32'h1);
        addr0 = 10'd2;
        @(negedge clock);
        chk("ws0_gap_ack", 32'(ack0), 32'h0);
        chk("ws0_gap_ready", 32'(ready0), 32'h1);
        @(negedge clock);
        chk("ws0_ack2", 32'(ack0), 32'h1);
        chk("ws0_out2", dout0, 32'h2);
        req0 = 1'b0;
        @(negedge clock);
        chk("ws0_ack_end", 32'(ack0), 32'h0);
        chk("ws0_out_hold", dout0, 32'h2);
        chk("ws0_stats_rd", 32'(rd_cnt0), STATS ? 32'd2 : 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
